// File: rtl/wb_pkg.sv
// Shared types and sizing for the writeback arbiter and its load queue.
package wb_pkg;
  localparam int WB_DEPTH_DEFAULT = 4;
  localparam int WB_PTR_W         = $clog2(WB_DEPTH_DEFAULT);

  typedef struct packed {
    logic        valid;
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_entry_t;
endpackage

// File: rtl/wb_fifo.sv
// Load-writeback queue: push at tail, multi-entry pop at head, invalidate-by-rd,
// and an oldest-first view of all slots with valid masked by occupancy.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = WB_DEPTH_DEFAULT,
  localparam int PW   = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  wb_entry_t              push_entry,
  input  logic [PW:0]            pop_n,
  input  logic                   inv_en,
  input  logic [4:0]             inv_rd,
  output wb_entry_t [DEPTH-1:0]  view,
  output logic [PW:0]            count
);
  wb_entry_t       mem [DEPTH];
  logic [PW-1:0]   head;
  logic [PW-1:0]   tail;

  assign tail = head + count[PW-1:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (inv_en)
        for (int i = 0; i < DEPTH; i++)
          if (mem[i].rd == inv_rd) mem[i].valid <= 1'b0;
      // tail slot is unoccupied, so a push never collides with a live entry
      if (push) mem[tail] <= push_entry;
      head  <= head + pop_n[PW-1:0];
      count <= count - pop_n + (PW+1)'(push);
    end
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      view[i]       = mem[head + PW'(i)];
      view[i].valid = mem[head + PW'(i)].valid && ((PW+1)'(i) < count);
    end
  end
endmodule

// File: rtl/wb_arbiter.sv
// Register-file writeback arbiter: ALU > queued load > direct load, one registered write per cycle.
// Define WB_FWD_EN to build the decode-stage forwarding network; otherwise fwd outputs are 0.
module wb_arbiter
  import wb_pkg::*;
#(
  parameter int DEPTH = WB_DEPTH_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        alu_valid,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_data,
  input  logic        ld_valid,
  input  logic [4:0]  ld_rd,
  input  logic [31:0] ld_data,
  output logic        ld_ready,
  output logic        we3,
  output logic [4:0]  a3,
  output logic [31:0] wd3,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  output logic        fwd1_hit,
  output logic        fwd2_hit,
  output logic [31:0] fwd1_data,
  output logic [31:0] fwd2_data,
  output logic [3:0]  pending,
  output logic        busy
);
  localparam int PW = $clog2(DEPTH);

  wb_entry_t [DEPTH-1:0] view;
  wb_entry_t             head_e, push_e;
  logic [PW:0]           count, skip, pop_n;
  logic                  head_vld, alu_sel, q_sel, d_sel, ld_acc, ld_keep, push, sel_we;
  logic [4:0]            sel_rd;
  logic [31:0]           sel_data;

  // Leading invalidated entries are popped alongside whatever else happens this cycle.
  always_comb begin
    head_vld = 1'b0;
    head_e   = '0;
    skip     = '0;
    for (int i = 0; i < DEPTH; i++)
      if (!head_vld && ((PW+1)'(i) < count)) begin
        if (view[i].valid) begin
          head_vld = 1'b1;
          head_e   = view[i];
        end else begin
          skip = skip + (PW+1)'(1);
        end
      end
  end

  assign ld_ready = count < (PW+1)'(DEPTH);
  assign alu_sel  = alu_valid && (alu_rd != 5'd0);
  assign q_sel    = !alu_sel && head_vld;
  assign ld_acc   = ld_valid && ld_ready;
  // same-rd load alongside an ALU write is older, so it is simply dropped
  assign ld_keep  = ld_acc && (ld_rd != 5'd0) && !(alu_sel && (alu_rd == ld_rd));
  assign d_sel    = !alu_sel && !head_vld && ld_keep;
  assign push     = ld_keep && !d_sel;
  assign pop_n    = skip + (PW+1)'(q_sel);
  assign push_e   = '{valid: 1'b1, rd: ld_rd, data: ld_data};

  assign sel_we   = alu_sel || q_sel || d_sel;
  assign sel_rd   = alu_sel ? alu_rd   : q_sel ? head_e.rd   : ld_rd;
  assign sel_data = alu_sel ? alu_data : q_sel ? head_e.data : ld_data;

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .push_entry (push_e),
    .pop_n      (pop_n),
    .inv_en     (alu_sel),
    .inv_rd     (alu_rd),
    .view       (view),
    .count      (count)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      we3 <= 1'b0;
      a3  <= '0;
      wd3 <= '0;
    end else begin
      we3 <= sel_we;
      if (sel_we) begin
        a3  <= sel_rd;
        wd3 <= sel_data;
      end
    end
  end

  assign pending = 4'(count);
  assign busy    = (count != '0) || we3;

`ifdef WB_FWD_EN
  // Youngest matching queue entry wins; the registered write is older than any of them.
  function automatic logic [32:0] fwd_lookup(input logic [4:0] ra);
    logic [32:0] r;
    r = '0;
    if (ra != 5'd0) begin
      if (we3 && (a3 == ra)) r = {1'b1, wd3};
      for (int i = 0; i < DEPTH; i++)
        if (view[i].valid && (view[i].rd == ra)) r = {1'b1, view[i].data};
    end
    return r;
  endfunction

  assign {fwd1_hit, fwd1_data} = fwd_lookup(ra1);
  assign {fwd2_hit, fwd2_data} = fwd_lookup(ra2);
`else
  logic unused_ra;
  assign unused_ra = ^{ra1, ra2};
  assign fwd1_hit  = 1'b0;
  assign fwd2_hit  = 1'b0;
  assign fwd1_data = '0;
  assign fwd2_data = '0;
`endif
endmodule
